// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Stall/flush sequencer for a 5-stage RISC-V pipeline. Produces the enable and
// flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC
// write enable from the current hazard conditions. It freezes the pipeline
// while a MEM-stage bus access waits for ready, and traps a bus that never
// answers in a sticky error state. Two saturating counters record stalled
// cycles and taken-branch flushes.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   rs1_ID, rs2_ID           source register addresses of the ID instruction
//   rs1_used_ID, rs2_used_ID ID instruction actually reads rs1 / rs2
//   rd_EX                    destination register of the EX instruction
//   RegWrite_EX              EX instruction writes a register
//   DatatoReg_EX             EX instruction is a load
//   branch_taken_EX          EX resolved a taken branch/jump this cycle
//   MIO_MEM                  MEM instruction performs a bus access
//   mem_ready                bus access completes this cycle
//   PC_EN                    PC write enable (combinational)
//   IF_ID_EN, IF_ID_flush    IF/ID latch controls (combinational)
//   ID_EX_EN, ID_EX_flush    ID/EX latch controls (combinational)
//   EX_MEM_EN                EX/MEM latch enable (combinational)
//   MEM_WB_EN, MEM_WB_flush  MEM/WB latch controls (combinational)
//   mem_err                  sticky bus-timeout flag
//   stall_cnt                saturating count of cycles with PC_EN=0
//   flush_cnt                saturating count of honoured taken branches
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             rs1_used_ID,
    input  logic             rs2_used_ID,
    input  logic [4:0]       rd_EX,
    input  logic             RegWrite_EX,
    input  logic             DatatoReg_EX,
    input  logic             branch_taken_EX,
    input  logic             MIO_MEM,
    input  logic             mem_ready,
    output logic             PC_EN,
    output logic             IF_ID_EN,
    output logic             IF_ID_flush,
    output logic             ID_EX_EN,
    output logic             ID_EX_flush,
    output logic             EX_MEM_EN,
    output logic             MEM_WB_EN,
    output logic             MEM_WB_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Wait counter is wide enough for the largest supported timeout (255).
    localparam int unsigned          WAIT_W    = 8;
    localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]     CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              mem_err_q;
    logic              mem_err_nxt;

    logic              rs1_hit;
    logic              rs2_hit;
    logic              load_use;
    logic              mem_stall;
    logic              flush_taken;

    // Hazard detection: a load in EX feeding a register the ID instruction reads.
    assign rs1_hit   = rs1_used_ID && (rs1_ID == rd_EX);
    assign rs2_hit   = rs2_used_ID && (rs2_ID == rd_EX);
    assign load_use  = RegWrite_EX && DatatoReg_EX && (rd_EX != 5'd0)
                       && (rs1_hit || rs2_hit);
    assign mem_stall = MIO_MEM && !mem_ready;

    // State, wait counter, error flag and performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            mem_err_q <= mem_err_nxt;
            if (!PC_EN && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (flush_taken && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

    // Next-state logic for the bus-wait tracker.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_err_nxt  = mem_err_q;
        case (state)
            ST_RUN: begin
                if (mem_stall) begin
                    state_nxt    = ST_WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end
            end
            ST_WAIT: begin
                // Ready, or the access being withdrawn, both end the wait.
                if (!mem_stall) begin
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt    = ST_ERR;
                    mem_err_nxt  = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            ST_ERR: begin
                mem_err_nxt = 1'b1;
            end
            default: begin
                state_nxt    = ST_RUN;
                wait_cnt_nxt = '0;
                mem_err_nxt  = 1'b0;
            end
        endcase
    end

    // Latch controls, highest priority first: error, bus stall, branch, load-use.
    always_comb begin
        PC_EN        = 1'b1;
        IF_ID_EN     = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_EN     = 1'b1;
        ID_EX_flush  = 1'b0;
        EX_MEM_EN    = 1'b1;
        MEM_WB_EN    = 1'b1;
        MEM_WB_flush = 1'b0;
        mem_err      = 1'b0;
        flush_taken  = 1'b0;
        if (!rst) begin
            mem_err = mem_err_q;
            if (state == ST_ERR) begin
                PC_EN     = 1'b0;
                IF_ID_EN  = 1'b0;
                ID_EX_EN  = 1'b0;
                EX_MEM_EN = 1'b0;
                MEM_WB_EN = 1'b0;
            end else if (mem_stall) begin
                // Front of the pipe freezes; WB receives a bubble. A pending
                // branch stays in EX and is honoured on the release cycle.
                PC_EN        = 1'b0;
                IF_ID_EN     = 1'b0;
                ID_EX_EN     = 1'b0;
                EX_MEM_EN    = 1'b0;
                MEM_WB_flush = 1'b1;
            end else if (branch_taken_EX) begin
                // Wrong-path IF and ID instructions are discarded, which also
                // makes any load-use hazard on the ID instruction moot.
                IF_ID_flush = 1'b1;
                ID_EX_flush = 1'b1;
                flush_taken = 1'b1;
            end else if (load_use) begin
                // Hold IF and ID for one cycle and push a bubble into EX.
                PC_EN       = 1'b0;
                IF_ID_EN    = 1'b0;
                ID_EX_flush = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int unsigned TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_ID, rs2_ID, rd_EX;
    logic       rs1_used_ID, rs2_used_ID, RegWrite_EX, DatatoReg_EX;
    logic       branch_taken_EX, MIO_MEM, mem_ready;

    logic        PC_EN, IF_ID_EN, IF_ID_flush, ID_EX_EN, ID_EX_flush;
    logic        EX_MEM_EN, MEM_WB_EN, MEM_WB_flush, mem_err;
    logic [31:0] stall_cnt, flush_cnt;

    logic        pc4, ifen4, iff4, iden4, idf4, exen4, wben4, wbf4, err4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .rd_EX(rd_EX), .RegWrite_EX(RegWrite_EX), .DatatoReg_EX(DatatoReg_EX),
        .branch_taken_EX(branch_taken_EX), .MIO_MEM(MIO_MEM), .mem_ready(mem_ready),
        .PC_EN(PC_EN), .IF_ID_EN(IF_ID_EN), .IF_ID_flush(IF_ID_flush),
        .ID_EX_EN(ID_EX_EN), .ID_EX_flush(ID_EX_flush), .EX_MEM_EN(EX_MEM_EN),
        .MEM_WB_EN(MEM_WB_EN), .MEM_WB_flush(MEM_WB_flush), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .rd_EX(rd_EX), .RegWrite_EX(RegWrite_EX), .DatatoReg_EX(DatatoReg_EX),
        .branch_taken_EX(branch_taken_EX), .MIO_MEM(MIO_MEM), .mem_ready(mem_ready),
        .PC_EN(pc4), .IF_ID_EN(ifen4), .IF_ID_flush(iff4),
        .ID_EX_EN(iden4), .ID_EX_flush(idf4), .EX_MEM_EN(exen4),
        .MEM_WB_EN(wben4), .MEM_WB_flush(wbf4), .mem_err(err4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    always #5 clk = ~clk;

    // Observed bundles: both instances share stimulus and control behaviour.
    wire [17:0] obs_ctl = {PC_EN, IF_ID_EN, IF_ID_flush, ID_EX_EN, ID_EX_flush,
                           EX_MEM_EN, MEM_WB_EN, MEM_WB_flush, mem_err,
                           pc4, ifen4, iff4, iden4, idf4, exen4, wben4, wbf4, err4};
    wire [71:0] obs_cnt = {stall_cnt, flush_cnt, stall_cnt4, flush_cnt4};

    int n_vec = 0;
    int n_err = 0;

    // Reference model: error flag, consecutive stalled bus cycles, and the
    // true (unbounded) event counts; narrower counters are min(count, max).
    bit         m_err;
    int         m_consec;
    longint     m_stall;
    longint     m_flush;
    logic [8:0] exp_ctl;
    bit         exp_hon;

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [71:0] exp_cnt();
        return {32'(sat(m_stall, 64'hFFFF_FFFF)), 32'(sat(m_flush, 64'hFFFF_FFFF)),
                4'(sat(m_stall, 15)), 4'(sat(m_flush, 15))};
    endfunction

    // Expected controls, ordered {PC,IFID_EN,IFID_fl,IDEX_EN,IDEX_fl,EXMEM,MEMWB_EN,MEMWB_fl,err}.
    function automatic void model_eval();
        bit ms, lu;
        ms = MIO_MEM && !mem_ready;
        lu = RegWrite_EX && DatatoReg_EX && (rd_EX != 0) &&
             ((rs1_used_ID && rs1_ID == rd_EX) || (rs2_used_ID && rs2_ID == rd_EX));
        exp_hon = 1'b0;
        if (rst)                  exp_ctl = 9'b110101100;
        else if (m_err)           exp_ctl = 9'b000000001;
        else if (ms)              exp_ctl = 9'b000000110;
        else if (branch_taken_EX) begin exp_ctl = 9'b111111100; exp_hon = 1'b1; end
        else if (lu)              exp_ctl = 9'b000111100;
        else                      exp_ctl = 9'b110101100;
    endfunction

    function automatic void model_commit();
        if (rst) begin
            m_err = 0; m_consec = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!exp_ctl[8]) m_stall++;
            if (exp_hon)     m_flush++;
            if (!m_err) begin
                if (MIO_MEM && !mem_ready) begin
                    m_consec++;
                    if (m_consec == int'(TO)) m_err = 1;
                end else begin
                    m_consec = 0;
                end
            end
        end
    endfunction

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic drive(input logic r, input logic [4:0] a1, input logic u1,
                         input logic [4:0] a2, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic dr, input logic br,
                         input logic mio, input logic rdy);
        rst = r; rs1_ID = a1; rs1_used_ID = u1; rs2_ID = a2; rs2_used_ID = u2;
        rd_EX = rd; RegWrite_EX = rw; DatatoReg_EX = dr; branch_taken_EX = br;
        MIO_MEM = mio; mem_ready = rdy;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
                  5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1, 0);
            #1; model_eval();
            n_vec++;
            if (obs_ctl !== {exp_ctl, exp_ctl}) begin
                n_err++; $display("FAIL reset_ctl cyc%0d: got %b want %b", i, obs_ctl, {exp_ctl, exp_ctl});
            end
            tick();
        end
        idle(); #1;
        n_vec++;
        if (obs_cnt !== 72'd0) begin
            n_err++; $display("FAIL reset_cnt: got %h want 0", obs_cnt);
        end
    endtask

    task automatic test_load_use();
        // lw x5 in EX, ID reads x5 via rs1; then the load leaves EX.
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: drive(0, 5, 1, 9, 0, 5, 1, 1, 0, 0, 0);
                1: drive(0, 5, 1, 9, 0, 0, 0, 0, 0, 0, 0);
                2: drive(0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0);
                default: drive(0, 3, 0, 7, 1, 7, 1, 1, 0, 0, 0);
            endcase
            #1; model_eval();
            n_vec++;
            if (obs_ctl !== {exp_ctl, exp_ctl}) begin
                n_err++; $display("FAIL load_use_ctl cyc%0d: got %b want %b", i, obs_ctl, {exp_ctl, exp_ctl});
            end
            n_vec++;
            if (obs_cnt !== exp_cnt()) begin
                n_err++; $display("FAIL load_use_cnt cyc%0d: got %h want %h", i, obs_cnt, exp_cnt());
            end
            tick();
        end
        n_vec++;
        if (stall_cnt !== 32'd2) begin
            n_err++; $display("FAIL load_use_total: got %0d want 2", stall_cnt);
        end
        idle();
    endtask

    task automatic test_branch();
        longint s0, f0;
        s0 = m_stall; f0 = m_flush;
        drive(0, 5, 1, 0, 0, 5, 1, 1, 1, 0, 0);
        #1;
        n_vec++;
        if (obs_ctl !== {9'b111111100, 9'b111111100}) begin
            n_err++; $display("FAIL branch_ctl: got %b want %b", obs_ctl, {9'b111111100, 9'b111111100});
        end
        tick(); idle(); #1;
        n_vec++;
        if ({stall_cnt, flush_cnt} !== {32'(s0), 32'(f0 + 1)}) begin
            n_err++; $display("FAIL branch_cnt: got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, s0, f0 + 1);
        end
    endtask

    task automatic test_bus_wait();
        int stalled = 0;
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 1, 2, 1, 3, 1, 0, 0, i < 4, i == 3);
            #1; model_eval();
            if (!PC_EN && MEM_WB_flush) stalled++;
            n_vec++;
            if (obs_ctl !== {exp_ctl, exp_ctl}) begin
                n_err++; $display("FAIL bus_wait_ctl cyc%0d: got %b want %b", i, obs_ctl, {exp_ctl, exp_ctl});
            end
            n_vec++;
            if (obs_cnt !== exp_cnt()) begin
                n_err++; $display("FAIL bus_wait_cnt cyc%0d: got %h want %h", i, obs_cnt, exp_cnt());
            end
            tick();
        end
        n_vec++;
        if (stalled !== 3) begin
            n_err++; $display("FAIL bus_wait_len: got %0d want 3", stalled);
        end
        idle();
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < TO + 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, i >= TO);
            #1; model_eval();
            n_vec++;
            if (obs_ctl !== {exp_ctl, exp_ctl}) begin
                n_err++; $display("FAIL timeout_ctl cyc%0d: got %b want %b", i, obs_ctl, {exp_ctl, exp_ctl});
            end
            tick();
        end
        n_vec++;
        if ({mem_err, PC_EN, MEM_WB_EN} !== 3'b100) begin
            n_err++; $display("FAIL timeout_err: got %b want 100", {mem_err, PC_EN, MEM_WB_EN});
        end
        n_vec++;
        if (stall_cnt !== 32'(TO + 4)) begin
            n_err++; $display("FAIL timeout_stalls: got %0d want %0d", stall_cnt, TO + 4);
        end
        do_reset(); #1;
        n_vec++;
        if ({mem_err, obs_ctl[17:9], obs_cnt} !== {1'b0, 9'b110101100, 72'd0}) begin
            n_err++; $display("FAIL timeout_clear: got %b/%h want 0/110101100/0", mem_err, obs_cnt);
        end
    endtask

    task automatic test_priority();
        longint f0;
        f0 = m_flush;
        for (int i = 0; i < 4; i++) begin
            drive(0, 4, 1, 0, 0, 4, 1, 1, i < 3, 1, i >= 2);
            #1; model_eval();
            n_vec++;
            if (obs_ctl !== {exp_ctl, exp_ctl}) begin
                n_err++; $display("FAIL priority_ctl cyc%0d: got %b want %b", i, obs_ctl, {exp_ctl, exp_ctl});
            end
            tick();
        end
        n_vec++;
        if (flush_cnt !== 32'(f0 + 1)) begin
            n_err++; $display("FAIL priority_flush: got %0d want %0d", flush_cnt, f0 + 1);
        end
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 6, 1, 6, 1, 1, 0, 0, 0);
            tick();
        end
        #1;
        n_vec++;
        if ({stall_cnt4, stall_cnt} !== {4'd15, 32'd20}) begin
            n_err++; $display("FAIL saturation: got %0d/%0d want 15/20", stall_cnt4, stall_cnt);
        end
        idle();
    endtask

    task automatic test_reset_mid_wait();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        tick();
        // Back in RUN: a fresh stall must not be counted as a continuation.
        for (int i = 0; i < TO - 1; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            #1; model_eval();
            n_vec++;
            if ({obs_ctl, obs_cnt} !== {exp_ctl, exp_ctl, exp_cnt()}) begin
                n_err++; $display("FAIL reset_wait cyc%0d: got %b/%h want %b/%h", i, obs_ctl, obs_cnt, {exp_ctl, exp_ctl}, exp_cnt());
            end
            tick();
        end
        n_vec++;
        if (mem_err !== 1'b0) begin
            n_err++; $display("FAIL reset_wait_err: got %b want 0", mem_err);
        end
        idle(); tick();
    endtask

    task automatic test_random();
        bit busy = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) busy = ~busy;
            drive($urandom_range(0, 99) == 0,
                  5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 4) == 0, busy, $urandom_range(0, 5) == 0);
            #1; model_eval();
            n_vec++;
            if (obs_ctl !== {exp_ctl, exp_ctl}) begin
                n_err++; $display("FAIL random_ctl cyc%0d: got %b want %b", i, obs_ctl, {exp_ctl, exp_ctl});
            end
            n_vec++;
            if (obs_cnt !== exp_cnt()) begin
                n_err++; $display("FAIL random_cnt cyc%0d: got %h want %h", i, obs_cnt, exp_cnt());
            end
            tick();
        end
    endtask

    initial begin
        m_err = 0; m_consec = 0; m_stall = 0; m_flush = 0;
        idle();
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_branch();
        test_bus_wait();
        test_timeout();
        test_priority();
        test_saturation();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives the EN/flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB latches, and the PC write enable.
- Detects load-use hazards and taken-branch redirects.
- Freezes the pipeline while a MEM-stage bus access (MIO) waits for ready.
- Traps bus timeouts in a sticky error state and keeps saturating performance counters.

Parameters:
MEM_TIMEOUT, 16, max consecutive wait cycles before entering ERR (range 2..255)
CNT_W, 32, width of stall/flush performance counters

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
rst  in  1  reset (one clock; reset is synchronous and active-high)
rs1_ID  in  5  rs1 address of instruction in ID
rs2_ID  in  5  rs2 address of instruction in ID
rs1_used_ID  in  1  ID instruction reads rs1
rs2_used_ID  in  1  ID instruction reads rs2
rd_EX  in  5  destination of instruction in EX
RegWrite_EX  in  1  EX instruction writes register
DatatoReg_EX  in  1  EX instruction is a load (data from memory)
branch_taken_EX  in  1  EX resolved a taken branch/jump this cycle
MIO_MEM  in  1  MEM-stage instruction performs a bus access
mem_ready  in  1  bus access completes this cycle
PC_EN  out  1  PC register write enable
IF_ID_EN  out  1  IF/ID enable
IF_ID_flush  out  1  IF/ID flush
ID_EX_EN  out  1  ID/EX enable
ID_EX_flush  out  1  ID/EX flush (acts only with ID_EX_EN=1)
EX_MEM_EN  out  1  EX/MEM enable
MEM_WB_EN  out  1  MEM/WB enable
MEM_WB_flush  out  1  MEM/WB flush
mem_err  out  1  sticky bus-timeout flag
stall_cnt  out  CNT_W  cycles with PC_EN=0
flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- Enables and flushes are combinational from state and inputs. Only state, wait_cnt, mem_err and the counters are registered.
- While rst=1: all EN=1, all flush=0, mem_err=0. At the reset edge: state<=RUN, wait_cnt<=0, stall_cnt<=0, flush_cnt<=0.
- Defaults: all EN=1, all flush=0.

Condition definitions:
- mem_stall = MIO_MEM & ~mem_ready.
- load_use = RegWrite_EX & DatatoReg_EX & (rd_EX!=0) & ((rs1_used_ID & rs1_ID==rd_EX) | (rs2_used_ID & rs2_ID==rd_EX)).

Priority (highest first):
1. state ERR: PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN and MEM_WB_EN all 0; no flush.
2. mem_stall: PC_EN, IF_ID_EN, ID_EX_EN and EX_MEM_EN = 0; MEM_WB_EN=1 with MEM_WB_flush=1, so a bubble enters WB.
3. branch_taken_EX: IF_ID_flush=1, ID_EX_flush=1, all EN=1. Suppresses load_use, since the ID instruction is discarded.
4. load_use: PC_EN=0, IF_ID_EN=0, ID_EX_EN=1, ID_EX_flush=1. Exactly one bubble; the load then leaves EX, so load_use clears next cycle.

FSM:
- RUN:
  - mem_stall -> WAIT, wait_cnt<=1.
  - else stay.
- WAIT:
  - mem_ready=1 -> RUN, wait_cnt<=0. The pipeline advances in this same cycle, because mem_stall is already 0.
  - else if wait_cnt==MEM_TIMEOUT-1 -> ERR, mem_err<=1.
  - else wait_cnt<=wait_cnt+1.
  - MIO_MEM dropping to 0 while in WAIT is treated as completion -> RUN.
- ERR: absorbing until rst; mem_err stays 1.

Counters:
- stall_cnt increments every cycle with PC_EN=0, including ERR.
- flush_cnt increments on each cycle where branch_taken_EX is honoured (priority 3).
- Both counters saturate at all-ones; no wrap.
- rst in any state, including mid-WAIT or ERR, returns to RUN at the next edge with counters cleared.
- Simultaneous branch_taken_EX and mem_stall: the stall wins. The branch is held in EX and is honoured on the release cycle.

Test Plan:
- Load-use: EX holds lw x5 (RegWrite_EX=1, DatatoReg_EX=1, rd_EX=5); ID has rs1_ID=5, rs1_used_ID=1 -> one cycle with PC_EN=0, IF_ID_EN=0, ID_EX_flush=1; stall_cnt=1; no stall the next cycle. Repeat with rd_EX=0 -> no stall.
- Branch: branch_taken_EX=1 for one cycle together with load_use=1 -> IF_ID_flush=ID_EX_flush=1, PC_EN=1, flush_cnt=1, stall_cnt unchanged.
- Bus wait: MIO_MEM=1, mem_ready=0 for 3 cycles, then 1 -> PC_EN/IF_ID_EN/ID_EX_EN/EX_MEM_EN=0 and MEM_WB_flush=1 for exactly 3 cycles; all EN=1 on the 4th cycle; state returns to RUN; stall_cnt=3.
- Timeout: MIO_MEM=1, mem_ready=0 held, MEM_TIMEOUT=16 -> mem_err=1 after 16 stalled cycles; all EN=0 thereafter; mem_ready=1 has no effect; rst clears mem_err and restores RUN.
- Priority: mem_stall and branch_taken_EX together for 2 cycles, then mem_ready=1 -> no flush during the stall; flush honoured on the release cycle; flush_cnt=1.
- Saturation and reset: CNT_W=4, hold load_use for 20 cycles -> stall_cnt stops at 15. Assert rst mid-WAIT -> next cycle state RUN and both counters 0.
